// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word reads and
// buffers returned instructions for decode, squashing wrong-path responses.
module fetch_unit #(
   parameter int unsigned          XLEN       = 32,
   parameter logic [XLEN-1:0]      RESET_PC   = '0,
   parameter int unsigned          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemReady,
   input  logic            imemRespValid,
   input  logic [XLEN-1:0] imemRdata,
   input  logic            PCSource,
   input  logic [XLEN-1:0] redirectTarget,
   input  logic            stall,
   output logic            instrValid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instrPC,
   output logic [6:0]      OPCode,
   output logic [2:0]      funct3,
   output logic            funct7,
   output logic            fetchMisaligned
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_count;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [XLEN-1:0] data_mem [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
   logic            rst_q;

   logic            accept;
   logic            resp;
   logic            resp_dec;
   logic            push;
   logic            pop;
   logic [CW:0]     inflight;
   logic [CW-1:0]   outstanding_nxt;

   // Issue credit, handshake qualification and outstanding accounting
   always_comb begin
      inflight        = (CW+1)'(outstanding) + (CW+1)'(count);
      imemReq         = !rst && !PCSource && !fetchMisaligned &&
                        (inflight < (CW+1)'(FIFO_DEPTH));
      imemAddr        = pc;
      accept          = imemReq && imemReady;
      resp            = imemRespValid && !rst && !rst_q;
      resp_dec        = resp && (outstanding != '0);
      push            = resp && (drop_count == '0) && !PCSource;
      pop             = instrValid && !stall && !PCSource;
      outstanding_nxt = outstanding + CW'(accept) - CW'(resp_dec);
   end

   // Buffer head drives decode directly
   always_comb begin
      instrValid = (count != '0) && !rst;
      instr      = data_mem[rd_ptr];
      instrPC    = pc_mem[rd_ptr];
      OPCode     = instr[6:0];
      funct3     = instr[14:12];
      funct7     = instr[30];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc              <= RESET_PC;
         resp_pc         <= RESET_PC;
         outstanding     <= '0;
         drop_count      <= '0;
         count           <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         fetchMisaligned <= 1'b0;
         rst_q           <= 1'b1;
      end else begin
         rst_q       <= 1'b0;
         outstanding <= outstanding_nxt;
         if (PCSource) begin
            // Everything still in flight after this cycle is wrong-path
            pc              <= redirectTarget;
            resp_pc         <= redirectTarget;
            drop_count      <= outstanding_nxt;
            count           <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            fetchMisaligned <= (redirectTarget[1:0] != 2'b00);
         end else begin
            if (accept)
               pc <= pc + XLEN'(4);
            if (resp && (drop_count != '0))
               drop_count <= drop_count - CW'(1);
            if (push) begin
               wr_ptr  <= wr_ptr + AW'(1);
               resp_pc <= resp_pc + XLEN'(4);
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Instruction buffer storage
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= imemRdata;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && (count == CW'(FIFO_DEPTH))));

   a_no_spurious_resp : assert property (@(posedge clk) disable iff (rst || rst_q)
      !(imemRespValid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table on the default
// instance plus a hand sequence for PC wrap and mid-stream reset.
module tb_fetch_unit;

   logic        clk;
   int          errors;
   int          checks;

   logic        rst, imemReady, imemRespValid, PCSource, stall;
   logic [31:0] imemRdata, redirectTarget;
   logic        imemReq, instrValid, funct7, fetchMisaligned;
   logic [31:0] imemAddr, instr, instrPC;
   logic [6:0]  OPCode;
   logic [2:0]  funct3;

   logic        rst_b, ready_b, rv_b, pcs_b, stall_b;
   logic [31:0] rdata_b, tgt_b;
   logic        req_b, ival_b, f7_b, mis_b;
   logic [31:0] addr_b, instr_b, ipc_b;
   logic [6:0]  op_b;
   logic [2:0]  f3_b;

   fetch_unit u0 (
      .clk(clk), .rst(rst), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemReady(imemReady), .imemRespValid(imemRespValid), .imemRdata(imemRdata),
      .PCSource(PCSource), .redirectTarget(redirectTarget), .stall(stall),
      .instrValid(instrValid), .instr(instr), .instrPC(instrPC), .OPCode(OPCode),
      .funct3(funct3), .funct7(funct7), .fetchMisaligned(fetchMisaligned)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u1 (
      .clk(clk), .rst(rst_b), .imemReq(req_b), .imemAddr(addr_b),
      .imemReady(ready_b), .imemRespValid(rv_b), .imemRdata(rdata_b),
      .PCSource(pcs_b), .redirectTarget(tgt_b), .stall(stall_b),
      .instrValid(ival_b), .instr(instr_b), .instrPC(ipc_b), .OPCode(op_b),
      .funct3(f3_b), .funct7(f7_b), .fetchMisaligned(mis_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        pcs;
      logic [31:0] tgt;
      logic        stl;
      logic        req;
      logic [31:0] addr;
      logic        ival;
      logic [31:0] ipc;
      logic [31:0] ins;
      logic        mis;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                               input logic [31:0] rdata, input logic pcs,
                               input logic [31:0] tgt, input logic stl,
                               input logic req, input logic [31:0] addr,
                               input logic ival, input logic [31:0] ipc,
                               input logic [31:0] ins, input logic mis);
      vec_t v;
      v.rst = r;   v.rdy = rdy;   v.rv = rv;     v.rdata = rdata;
      v.pcs = pcs; v.tgt = tgt;   v.stl = stl;   v.req = req;
      v.addr = addr; v.ival = ival; v.ipc = ipc; v.ins = ins; v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      vec_t e;
      logic [31:0] dec_exp;
      errors = 0;
      checks = 0;

      //           rst rdy rv  rdata          pcs tgt            stl | req addr          iv  ipc           ins            mis
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, NOP,           0, 32'h0,         0,   1, 32'h4,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, NOP,           0, 32'h0,         0,   0, 32'h0,         1, 32'h0,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h8,         1, 32'h4,         NOP,           0));
      vecs.push_back(mk(0, 1, 1, NOP,           0, 32'h0,         0,   1, 32'hC,         0, 32'h0,         32'h0,         0));
      // decode stalled for five cycles: credit limit holds off requests
      vecs.push_back(mk(0, 1, 1, 32'h4000_5033, 0, 32'h0,         1,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'h8,         NOP,           0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h10,        1, 32'hC,         32'h4000_5033, 0));
      vecs.push_back(mk(0, 1, 1, 32'h00C1_2083, 0, 32'h0,         0,   1, 32'h14,        0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'h10,        32'h00C1_2083, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h18,        0, 32'h0,         32'h0,         0));
      // redirect with two requests in flight
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h100,       0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, 32'hDEAD_0013, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, 32'hBEEF_0013, 0, 32'h0,         0,   1, 32'h100,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, 32'h0000_7013, 0, 32'h0,         0,   1, 32'h104,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, 32'h4000_0033, 0, 32'h0,         0,   0, 32'h0,         1, 32'h100,       32'h0000_7013, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h108,       1, 32'h104,       32'h4000_0033, 0));
      // redirect coinciding with a response while one entry is buffered
      vecs.push_back(mk(0, 1, 1, 32'hBAD0_0013, 1, 32'h300,       1,   0, 32'h0,         1, 32'h104,       32'h4000_0033, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h300,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 0, 1, 32'h0000_1063, 0, 32'h0,         0,   1, 32'h304,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h304,       1, 32'h300,       32'h0000_1063, 0));
      // misaligned target blocks issue until an aligned redirect
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 32'h102,       0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 32'h200,       0,   0, 32'h0,         0, 32'h0,         32'h0,         1));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h200,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, 32'h0000_2003, 0, 32'h0,         0,   1, 32'h204,       0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 1, 1, NOP,           0, 32'h0,         0,   0, 32'h0,         1, 32'h200,       32'h0000_2003, 0));
      // reset with a buffered entry, then a stray response right after reset
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0,         0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0,         0));

      rst = 1'b1; imemReady = 1'b0; imemRespValid = 1'b0; imemRdata = '0;
      PCSource = 1'b0; redirectTarget = '0; stall = 1'b0;
      rst_b = 1'b1; ready_b = 1'b0; rv_b = 1'b0; rdata_b = '0;
      pcs_b = 1'b0; tgt_b = '0; stall_b = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         e = vecs[i];
         @(negedge clk);
         rst = e.rst; imemReady = e.rdy; imemRespValid = e.rv; imemRdata = e.rdata;
         PCSource = e.pcs; redirectTarget = e.tgt; stall = e.stl;
         #1;
         chk("imemReq", i, 32'(imemReq), 32'(e.req));
         if (e.req)
            chk("imemAddr", i, imemAddr, e.addr);
         chk("instrValid", i, 32'(instrValid), 32'(e.ival));
         if (e.ival) begin
            dec_exp = {20'h0, e.ins[6:0], e.ins[14:12], 1'b0, e.ins[30]};
            chk("instr", i, instr, e.ins);
            chk("instrPC", i, instrPC, e.ipc);
            chk("decode", i, {20'h0, OPCode, funct3, 1'b0, funct7}, dec_exp);
         end
         chk("fetchMisaligned", i, 32'(fetchMisaligned), 32'(e.mis));
      end

      // Wrapping reset PC and mid-stream reset on the second instance
      @(negedge clk);
      rst_b = 1'b0; ready_b = 1'b1; rv_b = 1'b0;
      #1;
      chk("wrap_req0", 0, 32'(req_b), 32'h1);
      chk("wrap_addr0", 0, addr_b, 32'hFFFF_FFF8);
      chk("wrap_mis", 0, 32'(mis_b), 32'h0);
      @(negedge clk);
      rv_b = 1'b1; rdata_b = NOP;
      #1;
      chk("wrap_addr1", 1, addr_b, 32'hFFFF_FFFC);
      chk("wrap_ival1", 1, 32'(ival_b), 32'h0);
      @(negedge clk);
      rv_b = 1'b1; rdata_b = NOP;
      #1;
      chk("wrap_req2", 2, 32'(req_b), 32'h0);
      chk("wrap_ival2", 2, 32'(ival_b), 32'h1);
      chk("wrap_ipc2", 2, ipc_b, 32'hFFFF_FFF8);
      chk("wrap_instr2", 2, instr_b, NOP);
      chk("wrap_decode2", 2, {20'h0, op_b, f3_b, 1'b0, f7_b}, {20'h0, 7'h13, 3'h0, 1'b0, 1'b0});
      @(negedge clk);
      rv_b = 1'b0;
      #1;
      chk("wrap_req3", 3, 32'(req_b), 32'h1);
      chk("wrap_addr3", 3, addr_b, 32'h0);
      chk("wrap_ipc3", 3, ipc_b, 32'hFFFF_FFFC);
      @(negedge clk);
      rst_b = 1'b1;
      #1;
      chk("rst_req", 4, 32'(req_b), 32'h0);
      chk("rst_ival", 4, 32'(ival_b), 32'h0);
      @(negedge clk);
      rst_b = 1'b0; ready_b = 1'b0;
      #1;
      chk("post_rst_req", 5, 32'(req_b), 32'h1);
      chk("post_rst_addr", 5, addr_b, 32'hFFFF_FFF8);
      chk("post_rst_ival", 5, 32'(ival_b), 32'h0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
